// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush arbitration and multi-cycle EX sequencing.
// Define PIPE_CTRL_PERF_EN to build the saturating stall_cycles counter.
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        flush_req,
    input  logic        mem_req_stall,
    input  logic        ex_op_madd,
    input  logic        ex_op_div,
    input  logic        id_req_stall,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        madd_phase,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MADD2 = 2'd1,
        S_DIV   = 2'd2
    } state_t;

    localparam logic [5:0] STALL_MEM = 6'b011111;
    localparam logic [5:0] STALL_EX  = 6'b001111;
    localparam logic [5:0] STALL_ID  = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic             w_madd_phase;
    logic             w_div_busy;
    logic             w_div_done;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A MEM wait freezes the sequencer; a flush aborts it outright.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush_req) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (!mem_req_stall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (ex_op_div) begin
                        w_state_nxt = S_DIV;
                        w_cnt_nxt   = CNT_LOAD;
                    end else if (ex_op_madd) begin
                        w_state_nxt = S_MADD2;
                    end
                end
                S_MADD2: w_state_nxt = S_IDLE;
                S_DIV: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall      = '0;
        w_flush      = 1'b0;
        w_madd_phase = 1'b0;
        w_div_busy   = 1'b0;
        w_div_done   = 1'b0;
        if (!rst_) begin
            w_madd_phase = (r_state == S_MADD2);
            w_div_busy   = (r_state == S_DIV);
            if (flush_req) begin
                w_flush = 1'b1;
            end else if (mem_req_stall) begin
                w_stall = STALL_MEM;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (ex_op_div || ex_op_madd) begin
                            w_stall = STALL_EX;
                        end else if (id_req_stall) begin
                            w_stall = STALL_ID;
                        end
                    end
                    S_MADD2: w_stall = '0;
                    S_DIV: begin
                        if (r_cnt != '0) begin
                            w_stall = STALL_EX;
                        end else begin
                            w_div_done = 1'b1;
                        end
                    end
                    default: w_stall = '0;
                endcase
            end
        end
    end

    assign stall      = w_stall;
    assign flush      = w_flush;
    assign madd_phase = w_madd_phase;
    assign div_busy   = w_div_busy;
    assign div_done   = w_div_done;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_stall_cycles <= '0;
        end else if (w_stall != 6'd0 && r_stall_cycles != 32'hFFFF_FFFF) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table plus hand-written divide/madd/flush sequences,
// checked cycle by cycle through an expected-value queue.
module tb_pipe_ctrl;

    localparam int DIVC = 32;

    logic        clk = 1'b0;
    logic        rst_;
    logic        flush_req;
    logic        mem_req_stall;
    logic        ex_op_madd;
    logic        ex_op_div;
    logic        id_req_stall;
    logic [5:0]  stall;
    logic        flush;
    logic        madd_phase;
    logic        div_busy;
    logic        div_done;
    logic [31:0] stall_cycles;

    pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .flush_req     (flush_req),
        .mem_req_stall (mem_req_stall),
        .ex_op_madd    (ex_op_madd),
        .ex_op_div     (ex_op_div),
        .id_req_stall  (id_req_stall),
        .stall         (stall),
        .flush         (flush),
        .madd_phase    (madd_phase),
        .div_busy      (div_busy),
        .div_done      (div_done),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, fl, mem, madd, div, id;
        logic [5:0] stall;
        logic       flush, mp, busy, done;
        bit         care_st;
        string      name;
    } vec_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush, mp, busy, done;
        bit          care_st;
        logic [31:0] sc;
        bit          sc_chk;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sc_model = '0;
    bit          sc_known = 1'b0;
    vec_t        tbl[17];

    function automatic vec_t mk(input logic r, fl, mem, madd, div, id,
                                input logic [5:0] st,
                                input logic f, mp, busy, done,
                                input bit care, input string nm);
        vec_t v;
        v.rst = r; v.fl = fl; v.mem = mem; v.madd = madd; v.div = div; v.id = id;
        v.stall = st; v.flush = f; v.mp = mp; v.busy = busy; v.done = done;
        v.care_st = care; v.name = nm;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        logic [5:0] gm, em;
        rst_ = v.rst; flush_req = v.fl; mem_req_stall = v.mem;
        ex_op_madd = v.madd; ex_op_div = v.div; id_req_stall = v.id;
        e.stall = v.stall; e.flush = v.flush; e.mp = v.mp; e.busy = v.busy;
        e.done = v.done; e.care_st = v.care_st; e.name = v.name;
        e.sc = sc_model; e.sc_chk = sc_known;
        sb.push_back(e);
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            g = sb.pop_front();
            gm = {stall[4:0], flush};
            em = {g.stall[4:0], g.flush};
            if (stall !== g.stall || flush !== g.flush || div_done !== g.done ||
                (g.care_st && (madd_phase !== g.mp || div_busy !== g.busy))) begin
                failures++;
                $display("FAIL %s: got stall=%b flush=%b mp=%b busy=%b done=%b exp stall=%b flush=%b mp=%b busy=%b done=%b (st %0d/%0d)",
                         g.name, stall, flush, madd_phase, div_busy, div_done,
                         g.stall, g.flush, g.mp, g.busy, g.done, gm, em);
            end
            if (g.sc_chk) begin
                checks++;
                if (stall_cycles !== g.sc) begin
                    failures++;
                    $display("FAIL %s/stall_cycles: got %0d exp %0d",
                             g.name, stall_cycles, g.sc);
                end
            end
        end
`ifdef PIPE_CTRL_PERF_EN
        if (v.rst) begin
            sc_model = '0;
            sc_known = 1'b1;
        end else if (v.stall != 6'd0 && sc_model != 32'hFFFF_FFFF) begin
            sc_model = sc_model + 32'd1;
        end
`else
        sc_known = 1'b1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic fl, mem, madd, div, id,
                       input logic [5:0] st,
                       input logic f, mp, busy, done,
                       input bit care, input string nm);
        apply(mk(1'b0, fl, mem, madd, div, id, st, f, mp, busy, done, care, nm));
    endtask

    initial begin
        tbl[0]  = mk(1,1,1,1,1,1, 6'b000000, 0,0,0,0, 1, "rst_all_hi_a");
        tbl[1]  = mk(1,1,1,1,1,1, 6'b000000, 0,0,0,0, 1, "rst_all_hi_b");
        tbl[2]  = mk(0,0,0,0,0,0, 6'b000000, 0,0,0,0, 1, "idle_after_rst");
        tbl[3]  = mk(0,0,0,0,0,1, 6'b000111, 0,0,0,0, 1, "id_alone");
        tbl[4]  = mk(0,0,1,0,0,1, 6'b011111, 0,0,0,0, 1, "id_with_mem");
        tbl[5]  = mk(0,0,0,1,0,1, 6'b001111, 0,0,0,0, 1, "id_with_madd");
        tbl[6]  = mk(0,0,0,0,0,0, 6'b000000, 0,1,0,0, 1, "madd_phase2");
        tbl[7]  = mk(0,0,0,0,0,0, 6'b000000, 0,0,0,0, 1, "madd_back_idle");
        tbl[8]  = mk(0,0,0,1,1,0, 6'b001111, 0,0,0,0, 1, "div_beats_madd");
        tbl[9]  = mk(1,0,0,0,1,0, 6'b000000, 0,0,0,0, 1, "rst_mid_div");
        tbl[10] = mk(0,0,0,0,0,0, 6'b000000, 0,0,0,0, 1, "idle_after_rst_div");
        tbl[11] = mk(0,0,0,1,0,0, 6'b001111, 0,0,0,0, 1, "madd_start");
        tbl[12] = mk(0,0,0,1,1,1, 6'b000000, 0,1,0,0, 1, "madd2_ignores_ex");
        tbl[13] = mk(0,0,0,0,1,0, 6'b001111, 0,0,0,0, 1, "div_after_madd");
        tbl[14] = mk(0,1,0,0,0,0, 6'b000000, 1,0,0,0, 0, "flush_div");
        tbl[15] = mk(0,1,1,0,1,1, 6'b000000, 1,0,0,0, 1, "flush_beats_all");
        tbl[16] = mk(0,0,0,0,0,0, 6'b000000, 0,0,0,0, 1, "idle_after_flush");

        rst_ = 1'b1; flush_req = 1'b0; mem_req_stall = 1'b0;
        ex_op_madd = 1'b0; ex_op_div = 1'b0; id_req_stall = 1'b0;

        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // Plain divide: 31 stall cycles, done in cycle 32.
        cyc(0,0,0,1,0, 6'b001111, 0,0,0,0, 1, "divA_start");
        for (int k = 2; k < DIVC; k++)
            cyc(0,0,0,0,(k == 5), 6'b001111, 0,0,1,0, 1, "divA_run");
        cyc(0,0,0,0,0, 6'b000000, 0,0,1,1, 1, "divA_done");
        cyc(0,0,0,0,0, 6'b000000, 0,0,0,0, 1, "divA_idle");

        // Divide with a 5-cycle MEM wait at cycles 10..14: done at 37.
        cyc(0,0,0,1,0, 6'b001111, 0,0,0,0, 1, "divB_start");
        for (int k = 2; k <= 36; k++) begin
            if (k >= 10 && k <= 14)
                cyc(0,1,0,0,0, 6'b011111, 0,0,1,0, 1, "divB_memwait");
            else
                cyc(0,0,0,0,0, 6'b001111, 0,0,1,0, 1, "divB_run");
        end
        cyc(0,0,0,0,0, 6'b000000, 0,0,1,1, 1, "divB_done37");
        cyc(0,0,1,0,0, 6'b001111, 0,0,0,0, 1, "madd_back_to_back");
        cyc(0,0,0,0,0, 6'b000000, 0,1,0,0, 1, "madd_b2b_phase");

        // Flush at cycle 8 of a divide, then an immediate restart.
        cyc(0,0,0,1,0, 6'b001111, 0,0,0,0, 1, "divC_start");
        for (int k = 2; k < 8; k++)
            cyc(0,0,0,0,0, 6'b001111, 0,0,1,0, 1, "divC_run");
        cyc(1,0,0,0,0, 6'b000000, 1,0,0,0, 0, "divC_flush");
        cyc(0,0,0,1,0, 6'b001111, 0,0,0,0, 1, "divD_restart");
        for (int k = 2; k < DIVC; k++)
            cyc(0,0,0,0,0, 6'b001111, 0,0,1,0, 1, "divD_run");
        cyc(0,0,0,0,0, 6'b000000, 0,0,1,1, 1, "divD_done");
        cyc(0,0,0,0,0, 6'b000000, 0,0,0,0, 1, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It drives the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers, and the common flush. It arbitrates stall requests from ID, EX and MEM, and sequences multi-cycle EX operations: two-cycle multiply-accumulate and an iterative divide of fixed length. It sits beside the pipeline registers and owns every hold/clear decision for them.

## Interface
Parameters:
- DIV_CYCLES, 32, EX cycles a divide occupies; legal range 2..255.
- CNT_W, $clog2(DIV_CYCLES), divide counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_  in  1  reset; synchronous, active-high.
- flush_req  in  1  exception/ERET flush request from MEM.
- mem_req_stall  in  1  MEM bus wait.
- ex_op_madd  in  1  EX holds a madd/msub in its first phase.
- ex_op_div  in  1  EX holds a div/divu start.
- id_req_stall  in  1  ID load-use hazard.
- stall  out  6  hold vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush  out  1  clear all pipeline registers this cycle.
- madd_phase  out  1  EX in second madd phase; use stored product.
- div_busy  out  1  divide in progress.
- div_done  out  1  divide result valid in EX this cycle.
- stall_cycles  out  32  cycles with stall != 0.

## Operation
- State register: IDLE, MADD2, DIV. Counter cnt[CNT_W-1:0]. Outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Reset (rst_ high at edge): state=IDLE, cnt=0, stall_cycles=0. While rst_ is high, stall=0, flush=0, madd_phase=0, div_busy=0, div_done=0 regardless of inputs.
- Priority, highest first: flush_req > mem_req_stall > EX sequencing > id_req_stall.
- flush_req (any state): flush=1, stall=0. Next state=IDLE and cnt=0, so an in-flight madd/divide is aborted. div_done=0.
- mem_req_stall: stall=6'b011111. State and cnt frozen. madd_phase/div_busy keep their state-derived values. div_done=0.
- IDLE:
  - ex_op_div: stall=6'b001111, cnt<=DIV_CYCLES-2, next DIV.
  - Else ex_op_madd: stall=6'b001111, next MADD2.
  - Else id_req_stall: stall=6'b000111.
  - Else stall=0.
  - If ex_op_div and ex_op_madd are both high, div wins.
- MADD2: madd_phase=1, stall=0, next IDLE. EX inputs are ignored in this state.
- DIV: div_busy=1.
  - cnt!=0: stall=6'b001111, cnt decrements.
  - cnt==0: div_done=1, stall=0, next IDLE.
- id_req_stall is ignored in MADD2/DIV: EX is already the youngest active stage, or is released that cycle.

## Timing
- Stall/flush respond in the same cycle as the request (zero latency). State changes take effect next cycle.
- Divide: EX stalled for exactly DIV_CYCLES-1 cycles (start cycle included). div_done is asserted in cycle DIV_CYCLES, counted from the start cycle = 1. Total EX occupancy is DIV_CYCLES plus the number of mem_req_stall cycles.
- madd: exactly one stall cycle, then one madd_phase cycle.
- A new ex_op_div/ex_op_madd is accepted in the cycle after div_done or madd_phase. Back-to-back operations are legal.
- Reset mid-divide: the next cycle is IDLE with all outputs 0.

## Configuration
- PIPE_CTRL_PERF_EN defined: stall_cycles increments on every non-reset cycle with stall!=0. It saturates at 32'hFFFFFFFF and never wraps. flush cycles are not counted.
- Not defined: counter not instantiated; stall_cycles tied to 32'h0. All other behaviour is identical.

## Test plan
- Reset with all requests high -> stall=0, flush=0, div_busy=0 during reset. After release with inputs low: state IDLE, stall_cycles=0.
- DIV_CYCLES=32, one-cycle ex_op_div pulse -> stall=6'b001111 for 31 consecutive cycles, div_done=1 in cycle 32 with stall=0. stall_cycles=31 if PERF_EN.
- ex_op_madd pulse -> stall=6'b001111 for 1 cycle, then madd_phase=1 and stall=0 for 1 cycle, then IDLE.
- Divide start, mem_req_stall high for 5 cycles at cycle 10 -> stall=6'b011111 for those 5 cycles, cnt frozen, div_done at cycle 37.
- flush_req at cycle 8 of a divide -> flush=1, stall=0, div_done never asserted. Next cycle div_busy=0 and a new ex_op_div is accepted.
- id_req_stall with ex_op_madd high -> stall=6'b001111. id_req_stall alone -> 6'b000111. id_req_stall with mem_req_stall -> 6'b011111.
